// File: rtl/sic_dispatch_pkg.sv
// ---------------------------------------------------------------------------
// sic_dispatch_pkg
// Shared types and constants for the SIC dispatch block.
//   sic_packet_t : decoded packet as exchanged between decoder, dispatch
//                  queue and the SIC execution units.
//   SIC_*        : field widths of sic_packet_t.
//   sic_idx_w()  : width of an index able to address n units (min. 1 bit).
// ---------------------------------------------------------------------------
package sic_dispatch_pkg;

  // issue_id is carried at its widest supported size; an instance with a
  // narrower ID_WIDTH zero-extends its counter into this field, so
  // ID_WIDTH must not exceed SIC_ID_MAX_W.
  localparam int SIC_ID_MAX_W  = 16;
  localparam int SIC_OPCODE_W  = 8;
  localparam int SIC_OPERAND_W = 16;

  typedef struct packed {
    logic                     valid;
    logic [SIC_ID_MAX_W-1:0]  issue_id;
    logic [SIC_OPCODE_W-1:0]  opcode;
    logic [SIC_OPERAND_W-1:0] operand;
  } sic_packet_t;

  function automatic int sic_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sic_dispatch_if.sv
// ---------------------------------------------------------------------------
// sic_dispatch_if
// Bundles the decoder-side and SIC-side signals of sic_dispatch.
//   in_valid/in_pkt/in_ready : decoder -> dispatch packet handshake
//   flush                    : PC-redirect discard pulse
//   sic_req                  : per-SIC instruction request
//   sic_pkt                  : per-SIC packet, framed by its valid bit
//   occupancy                : current number of queued packets
// modport master : the decoder / environment side
// modport slave  : the dispatch block itself
// ---------------------------------------------------------------------------
interface sic_dispatch_if
  import sic_dispatch_pkg::*;
#(
  parameter int NUM_SIC = 4,
  parameter int DEPTH   = 8
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic                      in_valid;
  sic_packet_t               in_pkt;
  logic                      in_ready;
  logic                      flush;
  logic [NUM_SIC-1:0]        sic_req;
  sic_packet_t [NUM_SIC-1:0] sic_pkt;
  logic [OCC_W-1:0]          occupancy;

  modport master (
    output in_valid,
    output in_pkt,
    output flush,
    output sic_req,
    input  in_ready,
    input  sic_pkt,
    input  occupancy
  );

  modport slave (
    input  in_valid,
    input  in_pkt,
    input  flush,
    input  sic_req,
    output in_ready,
    output sic_pkt,
    output occupancy
  );

endinterface

// File: rtl/sic_rr_arbiter.sv
// ---------------------------------------------------------------------------
// sic_rr_arbiter
// Round-robin arbiter over NUM_SIC requesters. The search starts at rr_ptr;
// after a grant to unit i the pointer moves to (i+1) mod NUM_SIC, and it
// holds when nothing is granted.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req_i      : requests, already qualified by the caller
//   gnt_o      : one-hot grant (all zero when no request)
//   gnt_idx_o  : index of the granted unit (0 when no grant)
// ---------------------------------------------------------------------------
module sic_rr_arbiter
  import sic_dispatch_pkg::*;
#(
  parameter int NUM_SIC = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SIC-1:0]            req_i,
  output logic [NUM_SIC-1:0]            gnt_o,
  output logic [sic_idx_w(NUM_SIC)-1:0] gnt_idx_o
);

  localparam int IDX_W = sic_idx_w(NUM_SIC);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SIC - 1);

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] cand;
  logic             found;

  // Walk the requesters starting at rr_ptr and take the first one set.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_SIC; k++) begin
      cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_SIC);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        gnt_idx_o   = cand;
      end
    end
  end

  // Pointer moves just past the winner, wrapping at NUM_SIC.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (found) begin
      rr_ptr_d = (gnt_idx_o == LAST_IDX) ? '0 : gnt_idx_o + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/sic_dispatch.sv
// ---------------------------------------------------------------------------
// sic_dispatch
// Queues decoded packets, stamps each with a sequential issue_id and hands
// them to SIC execution units in round-robin order. A delivered packet is
// presented on sic_pkt[i] with valid=1 for exactly one cycle.
// Parameters:
//   NUM_SIC  : number of SIC units served
//   DEPTH    : FIFO entries (power of two, >= 2)
//   ID_WIDTH : issue_id counter width (<= SIC_ID_MAX_W)
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : sic_dispatch_if.slave (in_valid, in_pkt, in_ready, flush,
//                sic_req, sic_pkt, occupancy)
// ---------------------------------------------------------------------------
module sic_dispatch
  import sic_dispatch_pkg::*;
#(
  parameter int NUM_SIC  = 4,
  parameter int DEPTH    = 8,
  parameter int ID_WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  sic_dispatch_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int IDX_W = sic_idx_w(NUM_SIC);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  sic_packet_t               mem_q [DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]          occ_q, occ_d;
  logic [ID_WIDTH-1:0]       next_id_q, next_id_d;
  sic_packet_t [NUM_SIC-1:0] pkt_q, pkt_d;

  logic [NUM_SIC-1:0] out_busy;
  logic [NUM_SIC-1:0] arb_req;
  logic [NUM_SIC-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               fifo_empty;
  logic               enq;
  logic               pop;
  sic_packet_t        stamped;
  sic_packet_t        head;

  // Readiness looks only at the registered occupancy, so a pop in the same
  // cycle never opens a slot early; flush blocks enqueue outright.
  assign fifo_empty   = (occ_q == '0);
  assign bus.in_ready = (occ_q < OCC_FULL) && !bus.flush;
  assign enq          = bus.in_valid && bus.in_ready;
  assign head         = mem_q[rd_ptr_q];

  always_comb begin
    out_busy = '0;
    for (int i = 0; i < NUM_SIC; i++) begin
      out_busy[i] = pkt_q[i].valid;
    end
  end

  // A unit still showing a packet this cycle cannot take another; nothing is
  // granted from an empty queue or while a flush is discarding it.
  assign arb_req = (fifo_empty || bus.flush) ? '0 : (bus.sic_req & ~out_busy);
  assign pop     = |gnt;

  sic_rr_arbiter #(
    .NUM_SIC (NUM_SIC)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (arb_req),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  // The decoder's issue_id is replaced by the local counter.
  always_comb begin
    stamped          = bus.in_pkt;
    stamped.valid    = 1'b0;
    stamped.issue_id = SIC_ID_MAX_W'(next_id_q);
  end

  // Storage is only written; reads happen through the registered rd_ptr, so
  // a newly written entry is seen no earlier than the following cycle.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_q[wr_ptr_q] <= stamped;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power
  // of two. The issue_id counter is not touched by flush.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    occ_d     = occ_q;
    next_id_d = next_id_q;
    if (enq) begin
      wr_ptr_d  = wr_ptr_q + PTR_W'(1);
      next_id_d = next_id_q + ID_WIDTH'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({enq, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end
  end

  // Output slots: every valid drops after one cycle; the granted slot is
  // loaded from the FIFO head. Payload of idle slots is left as is.
  always_comb begin
    pkt_d = pkt_q;
    for (int i = 0; i < NUM_SIC; i++) begin
      pkt_d[i].valid = 1'b0;
    end
    if (pop) begin
      pkt_d[gnt_idx]       = head;
      pkt_d[gnt_idx].valid = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      next_id_q <= '0;
      pkt_q     <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      next_id_q <= next_id_d;
      pkt_q     <= pkt_d;
    end
  end

  assign bus.sic_pkt   = pkt_q;
  assign bus.occupancy = occ_q;

endmodule

// File: tb/tb_sic_dispatch.sv
// ---------------------------------------------------------------------------
// tb_sic_dispatch
// Directed bench for sic_dispatch. Expected deliveries (target SIC, issue_id,
// payload) are queued when a packet is accepted and matched whenever any
// sic_pkt valid appears. A second instance with ID_WIDTH=3 exercises the
// issue_id wrap.
// ---------------------------------------------------------------------------
module tb_sic_dispatch;
  import sic_dispatch_pkg::*;

  typedef struct packed {
    logic [7:0]  sic;
    logic [15:0] id;
    logic [7:0]  op;
    logic [15:0] operand;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  exp_t       sbq[$];
  exp_t       sbq3[$];
  logic [7:0] expId;
  logic [2:0] expId3;
  logic [7:0] opSeed;
  logic [3:0] vld, vld3, prevVld, prevVld3;

  sic_dispatch_if #(.NUM_SIC(4), .DEPTH(8))  bus  ();
  sic_dispatch_if #(.NUM_SIC(4), .DEPTH(16)) bus3 ();

  sic_dispatch #(.NUM_SIC(4), .DEPTH(8), .ID_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  sic_dispatch #(.NUM_SIC(4), .DEPTH(16), .ID_WIDTH(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  always_comb begin
    vld  = '0;
    vld3 = '0;
    for (int i = 0; i < 4; i++) begin
      vld[i]  = bus.sic_pkt[i].valid;
      vld3[i] = bus3.sic_pkt[i].valid;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] op, input logic [15:0] opnd,
                               input logic [3:0] req, input logic fl);
    bus.in_valid        = v;
    bus.in_pkt          = '0;
    bus.in_pkt.issue_id = 16'hBEEF;
    bus.in_pkt.opcode   = op;
    bus.in_pkt.operand  = opnd;
    bus.sic_req         = req;
    bus.flush           = fl;
  endtask

  // Offer one packet to the main instance; it is expected to be accepted now.
  task automatic sendPkt(input logic [7:0] sic, input logic [3:0] req);
    logic [15:0] opnd;
    opnd = 16'($urandom);
    applyStimulus(1'b1, opSeed, opnd, req, 1'b0);
    @(negedge clk);
    checkOutput("in_ready_send", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    sbq.push_back({sic, 8'h00, expId, opSeed, opnd});
    expId  = expId + 8'd1;
    opSeed = opSeed + 8'd1;
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic sendPkt3(input logic [7:0] sic);
    logic [15:0] opnd;
    opnd = 16'($urandom);
    bus3.in_valid        = 1'b1;
    bus3.in_pkt          = '0;
    bus3.in_pkt.opcode   = opSeed;
    bus3.in_pkt.operand  = opnd;
    @(negedge clk);
    checkOutput("in_ready_send3", 64'(bus3.in_ready), 64'd1);
    @(posedge clk);
    sbq3.push_back({sic, 13'd0, expId3, opSeed, opnd});
    expId3 = expId3 + 3'd1;
    opSeed = opSeed + 8'd1;
    #1;
    bus3.in_valid = 1'b0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'h00, 16'h0000, 4'b0000, 1'b0);
    bus3.in_valid = 1'b0;
    bus3.in_pkt   = '0;
    bus3.flush    = 1'b0;
    bus3.sic_req  = 4'b1111;
    sbq.delete();
    sbq3.delete();
    expId  = 8'd0;
    expId3 = 3'd0;
    @(negedge clk);
    checkOutput("reset_occ", 64'(bus.occupancy), 64'd0);
    checkOutput("reset_valid", 64'(vld), 64'd0);
    checkOutput("reset_occ3", 64'(bus3.occupancy), 64'd0);
    checkOutput("reset_valid3", 64'(vld3), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("in_ready_after_reset", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain(input int maxCycles);
    int n;
    n = 0;
    while ((sbq.size() != 0 || sbq3.size() != 0) && n < maxCycles) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain_pending", 64'(sbq.size() + sbq3.size()), 64'd0);
    @(negedge clk);
    checkOutput("occ_after_drain", 64'(bus.occupancy), 64'd0);
    checkOutput("occ3_after_drain", 64'(bus3.occupancy), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: every delivery must match the oldest expectation, and
  // a unit can never be shown a packet two cycles running.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prevVld  <= '0;
      prevVld3 <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (vld[i]) begin
          checkOutput("one_cycle_valid", 64'(prevVld[i]), 64'd0);
          checkOutput("delivery_expected", 64'(sbq.size() != 0), 64'd1);
          if (sbq.size() != 0) begin
            e = sbq.pop_front();
            checkOutput("delivery", {16'd0, 8'(i), bus.sic_pkt[i].issue_id,
                        bus.sic_pkt[i].opcode, bus.sic_pkt[i].operand}, {16'd0, e});
          end
        end
        if (vld3[i]) begin
          checkOutput("one_cycle_valid3", 64'(prevVld3[i]), 64'd0);
          checkOutput("delivery3_expected", 64'(sbq3.size() != 0), 64'd1);
          if (sbq3.size() != 0) begin
            e = sbq3.pop_front();
            checkOutput("delivery3", {16'd0, 8'(i), bus3.sic_pkt[i].issue_id,
                        bus3.sic_pkt[i].opcode, bus3.sic_pkt[i].operand}, {16'd0, e});
          end
        end
      end
      prevVld  <= vld;
      prevVld3 <= vld3;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    opSeed = 8'h10;
    doReset();

    // Only SIC2 requesting: three back-to-back packets, ids 0,1,2.
    $display("[TB] single requester");
    for (int k = 0; k < 3; k++) sendPkt(8'd2, 4'b0100);
    waitDrain(40);

    // Reset with queued packets and one output valid.
    $display("[TB] mid-operation reset");
    for (int k = 0; k < 4; k++) sendPkt(8'd0, 4'b0000);
    applyStimulus(1'b0, 8'h00, 16'h0000, 4'b0001, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("pre_reset_occ", 64'(bus.occupancy), 64'd3);
    checkOutput("pre_reset_valid", 64'(vld), 64'b0001);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_occ", 64'(bus.occupancy), 64'd0);
    checkOutput("async_reset_valid", 64'(vld), 64'd0);
    doReset();

    // All four requesting with four queued: SIC0..3 on consecutive cycles.
    $display("[TB] round robin");
    for (int k = 0; k < 4; k++) sendPkt(8'(k), 4'b0000);
    applyStimulus(1'b0, 8'h00, 16'h0000, 4'b1111, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("rr_order", 64'(vld), 64'd1 << k);
    end
    applyStimulus(1'b0, 8'h00, 16'h0000, 4'b0000, 1'b0);
    @(posedge clk);
    #1;
    sendPkt(8'd0, 4'b1111);
    waitDrain(40);

    // Fill to DEPTH, hold a 9th, pop one, then the 9th enters with id 8.
    doReset();
    $display("[TB] full queue");
    for (int k = 0; k < 8; k++) sendPkt(8'(k % 4), 4'b0000);
    applyStimulus(1'b1, opSeed, 16'h5A5A, 4'b0000, 1'b0);
    @(negedge clk);
    checkOutput("full_in_ready", 64'(bus.in_ready), 64'd0);
    checkOutput("full_occ", 64'(bus.occupancy), 64'd8);
    @(posedge clk);
    @(negedge clk);
    checkOutput("held_occ", 64'(bus.occupancy), 64'd8);
    bus.sic_req = 4'b0001;
    #1;
    checkOutput("no_bypass_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    bus.sic_req = 4'b0000;
    @(negedge clk);
    checkOutput("after_pop_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("after_pop_occ", 64'(bus.occupancy), 64'd7);
    @(posedge clk);
    sbq.push_back({8'd0, 8'h00, expId, opSeed, 16'h5A5A});
    checkOutput("ninth_id_model", 64'(expId), 64'd8);
    expId  = expId + 8'd1;
    opSeed = opSeed + 8'd1;
    #1;
    applyStimulus(1'b0, 8'h00, 16'h0000, 4'b1111, 1'b0);
    @(negedge clk);
    checkOutput("refill_occ", 64'(bus.occupancy), 64'd8);
    waitDrain(60);

    // Flush with five queued while SIC0 requests; ids continue at 5.
    doReset();
    $display("[TB] flush");
    for (int k = 0; k < 5; k++) sendPkt(8'd0, 4'b0000);
    applyStimulus(1'b1, 8'hEE, 16'h1234, 4'b0001, 1'b1);
    @(negedge clk);
    checkOutput("flush_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    sbq.delete();
    #1;
    applyStimulus(1'b0, 8'h00, 16'h0000, 4'b0000, 1'b0);
    @(negedge clk);
    checkOutput("flush_occ", 64'(bus.occupancy), 64'd0);
    checkOutput("flush_valid", 64'(vld), 64'd0);
    @(posedge clk);
    #1;
    sendPkt(8'd0, 4'b0001);
    waitDrain(40);

    // Narrow counter: ten packets, ids 0..7 then 0,1.
    $display("[TB] id wrap");
    for (int k = 0; k < 10; k++) sendPkt3(8'(k % 4));
    waitDrain(60);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
